// File: rtl/acc_fp52_drain.sv
// Burst accumulator behind the fp(2,5) fused multiplier: sums signed beats and emits one wide sum per burst.
// Optional ACC_SAT_EN clamps the accumulator on overflow instead of wrapping.
module acc_fp52_drain #(
  parameter int IN_W    = 20,
  parameter int ACC_W   = 32,
  parameter int CNT_W   = 8,
  parameter int MAX_LEN = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [IN_W-1:0]  in_dat,
  input  logic             in_last,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [ACC_W-1:0] out_dat,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_ovf
);

  typedef enum logic {IDLE, ACC} state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d, out_dat_q, out_dat_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, out_cnt_q, out_cnt_d;
  logic               ovf_q, ovf_d, out_vld_q, out_vld_d, out_ovf_q, out_ovf_d;
  logic [ACC_W-1:0]   acc_base, dat_ext, sum, acc_nxt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               add_ovf, ovf_nxt, accept, take, closing;

  always_comb begin
    in_rdy   = !out_vld_q | out_rdy;
    accept   = in_vld & in_rdy;
    take     = out_vld_q & out_rdy;
    acc_base = (state_q == IDLE) ? '0 : acc_q;
    dat_ext  = {{(ACC_W-IN_W){in_dat[IN_W-1]}}, in_dat};
    sum      = acc_base + dat_ext;
    // Signed overflow: like-signed operands producing a result of the other sign.
    add_ovf  = (acc_base[ACC_W-1] == dat_ext[ACC_W-1]) && (sum[ACC_W-1] != acc_base[ACC_W-1]);
`ifdef ACC_SAT_EN
    if (add_ovf)
      acc_nxt = dat_ext[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else
      acc_nxt = sum;
`else
    acc_nxt  = sum;
`endif
    cnt_nxt  = ((state_q == IDLE) ? '0 : cnt_q) + CNT_W'(1);
    ovf_nxt  = ((state_q == ACC) & ovf_q) | add_ovf;
    closing  = in_last | (cnt_nxt == CNT_W'(MAX_LEN));
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    out_vld_d = out_vld_q;
    out_dat_d = out_dat_q;
    out_cnt_d = out_cnt_q;
    out_ovf_d = out_ovf_q;
    if (accept) begin
      if (closing) begin
        // A close in the same cycle as a take reloads the output, so out_vld never dips.
        state_d   = IDLE;
        acc_d     = '0;
        cnt_d     = '0;
        ovf_d     = 1'b0;
        out_vld_d = 1'b1;
        out_dat_d = acc_nxt;
        out_cnt_d = cnt_nxt;
        out_ovf_d = ovf_nxt;
      end else begin
        state_d = ACC;
        acc_d   = acc_nxt;
        cnt_d   = cnt_nxt;
        ovf_d   = ovf_nxt;
      end
    end
    if (take && !(accept && closing)) out_vld_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
      out_cnt_q <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      out_vld_q <= out_vld_d;
      out_dat_q <= out_dat_d;
      out_cnt_q <= out_cnt_d;
      out_ovf_q <= out_ovf_d;
    end
  end

  assign out_vld = out_vld_q;
  assign out_dat = out_dat_q;
  assign out_cnt = out_cnt_q;
  assign out_ovf = out_ovf_q;

endmodule

// File: tb/tb_acc_fp52_drain.sv
// Directed + scoreboard bench for acc_fp52_drain; three instances share one stimulus bus
// (default, MAX_LEN=4, ACC_W=24) so forced-close and overflow corners can be reached.
module tb_acc_fp52_drain;
  localparam int NBEATS = 10000;

  logic        clk = 1'b0, rst = 1'b1;
  logic        in_vld = 1'b0, in_last = 1'b0, out_rdy = 1'b1;
  logic [19:0] in_dat = '0;
  logic        m_rdy, m_vld, m_ovf, f_rdy, f_vld, f_ovf, o_rdy, o_vld, o_ovf;
  logic [31:0] m_dat, f_dat;
  logic [23:0] o_dat;
  logic [7:0]  m_cnt, f_cnt, o_cnt;
  int          checks = 0, failures = 0;

  always #5 clk = ~clk;

  acc_fp52_drain dut (.clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(m_rdy), .in_dat(in_dat),
    .in_last(in_last), .out_vld(m_vld), .out_rdy(out_rdy), .out_dat(m_dat), .out_cnt(m_cnt), .out_ovf(m_ovf));
  acc_fp52_drain #(.MAX_LEN(4)) dut_f (.clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(f_rdy), .in_dat(in_dat),
    .in_last(in_last), .out_vld(f_vld), .out_rdy(out_rdy), .out_dat(f_dat), .out_cnt(f_cnt), .out_ovf(f_ovf));
  acc_fp52_drain #(.ACC_W(24)) dut_o (.clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(o_rdy), .in_dat(in_dat),
    .in_last(in_last), .out_vld(o_vld), .out_rdy(out_rdy), .out_dat(o_dat), .out_cnt(o_cnt), .out_ovf(o_ovf));

  typedef struct {
    bit vld; int dat; bit last; bit ordy;
    bit e_rdy; bit e_vld; bit chk_d; int e_dat; int e_cnt; bit e_ovf;
  } vec_t;
  vec_t tv[12];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit v, input int d, input bit l, input bit r);
    @(negedge clk);
    in_vld = v; in_dat = 20'(d); in_last = l; out_rdy = r;
  endtask

  task automatic beat(input bit v, input int d, input bit l, input bit r);
    drive(v, d, l, r);
    @(posedge clk); #1;
  endtask

  task automatic do_rst;
    in_vld = 0; in_last = 0; in_dat = '0; out_rdy = 1;
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 0;
  endtask

  int     q_dat[$], q_cnt[$];
  bit     q_ovf[$];
  longint racc, s;
  int     rcnt, cur_dat, sent, cyc, e_d, e_c;
  bit     rovf, have, cur_last, e_o;
  logic [19:0] r20;

  initial begin
    tv[0]  = '{1, -7,      1, 1, 1, 1, 1, -7,      1, 0};
    tv[1]  = '{0, 0,       0, 1, 1, 0, 0, 0,       0, 0};
    tv[2]  = '{1, 5,       0, 1, 1, 0, 0, 0,       0, 0};
    tv[3]  = '{1, -3,      0, 1, 1, 0, 0, 0,       0, 0};
    tv[4]  = '{1, 10,      1, 1, 1, 1, 1, 12,      3, 0};
    tv[5]  = '{1, 99,      1, 0, 0, 1, 1, 12,      3, 0};
    tv[6]  = '{1, 4,       1, 1, 1, 1, 1, 4,       1, 0};
    tv[7]  = '{1, -100000, 0, 1, 1, 0, 0, 0,       0, 0};
    tv[8]  = '{1, -200000, 1, 1, 1, 1, 1, -300000, 2, 0};
    tv[9]  = '{1, 1,       0, 0, 0, 1, 1, -300000, 2, 0};
    tv[10] = '{0, 0,       1, 1, 1, 0, 0, 0,       0, 0};
    tv[11] = '{1, 7,       1, 1, 1, 1, 1, 7,       1, 0};

    // Reset state
    do_rst;
    #1;
    chk("rst_vld", m_vld, 0); chk("rst_dat", m_dat, 0); chk("rst_cnt", m_cnt, 0);
    chk("rst_ovf", m_ovf, 0); chk("rst_rdy", m_rdy, 1);

    // Table-driven vectors on the default instance
    for (int i = 0; i < 12; i++) begin
      drive(tv[i].vld, tv[i].dat, tv[i].last, tv[i].ordy);
      #1 chk($sformatf("v%0d_rdy", i), m_rdy, tv[i].e_rdy);
      @(posedge clk); #1;
      chk($sformatf("v%0d_vld", i), m_vld, tv[i].e_vld);
      if (tv[i].chk_d) begin
        chk($sformatf("v%0d_dat", i), $signed(m_dat), tv[i].e_dat);
        chk($sformatf("v%0d_cnt", i), m_cnt, tv[i].e_cnt);
        chk($sformatf("v%0d_ovf", i), m_ovf, tv[i].e_ovf);
      end
    end

    // Reset mid-burst discards the partial sum and clears a held output
    do_rst;
    beat(1, 55, 1, 0);
    for (int k = 0; k < 3; k++) beat(1, 1, 0, 1);
    @(negedge clk); in_vld = 0;
    #2 rst = 1;
    #1;
    chk("mid_rst_vld", m_vld, 0); chk("mid_rst_dat", m_dat, 0); chk("mid_rst_cnt", m_cnt, 0);
    @(negedge clk) rst = 0;
    beat(1, 5, 0, 1); beat(1, -3, 0, 1); beat(1, 10, 1, 1);
    chk("post_rst_vld", m_vld, 1); chk("post_rst_dat", $signed(m_dat), 12); chk("post_rst_cnt", m_cnt, 3);

    // Backpressure hold for 10 clocks, then take + same-cycle close
    do_rst;
    beat(1, 33, 1, 1);
    for (int k = 0; k < 10; k++) begin
      drive(1, int'($urandom_range(1000)), 1, 0);
      #1 chk("bp_rdy", m_rdy, 0);
      @(posedge clk); #1;
      chk("bp_vld", m_vld, 1); chk("bp_dat", $signed(m_dat), 33);
    end
    beat(1, 4, 1, 1);
    chk("bp_rel_vld", m_vld, 1); chk("bp_rel_dat", $signed(m_dat), 4); chk("bp_rel_cnt", m_cnt, 1);

    // Forced close at MAX_LEN=4 with residual beats carried into the next burst
    do_rst;
    for (int k = 1; k <= 6; k++) begin
      beat(1, 1, 0, 1);
      if (k == 4) begin
        chk("fc_vld", f_vld, 1); chk("fc_dat", f_dat, 4); chk("fc_cnt", f_cnt, 4); chk("fc_ovf", f_ovf, 0);
      end
      if (k == 5) chk("fc_taken", f_vld, 0);
    end
    beat(1, 1, 1, 1);
    chk("fc_res_vld", f_vld, 1); chk("fc_res_dat", f_dat, 3); chk("fc_res_cnt", f_cnt, 3);

    // Overflow on a 24-bit accumulator: 16 beats fit, the 17th overflows
    do_rst;
    for (int k = 1; k <= 16; k++) beat(1, 'h7FFFF, k == 16, 1);
    chk("ov16_dat", o_dat, 24'h7FFFF0); chk("ov16_cnt", o_cnt, 16); chk("ov16_ovf", o_ovf, 0);
    for (int k = 1; k <= 17; k++) beat(1, 'h7FFFF, k == 17, 1);
    chk("ov17_vld", o_vld, 1); chk("ov17_cnt", o_cnt, 17); chk("ov17_ovf", o_ovf, 1);
`ifdef ACC_SAT_EN
    chk("ov17_dat", o_dat, 24'h7FFFFF);
`else
    chk("ov17_dat", o_dat, 24'h87FFEF);
`endif

    // Random traffic against a burst-level scoreboard
    do_rst;
    racc = 0; rcnt = 0; rovf = 0; have = 0; sent = 0; cyc = 0;
    while ((sent < NBEATS || q_dat.size() > 0) && cyc < 60000) begin
      @(negedge clk); cyc++;
      if (!have && sent < NBEATS) begin
        r20 = 20'($urandom);
        cur_dat = int'($signed(r20));
        cur_last = ($urandom_range(7) == 0);
        have = 1;
      end
      in_vld = have && ($urandom_range(1) == 1);
      in_dat = 20'(cur_dat); in_last = cur_last;
      out_rdy = (sent >= NBEATS) ? 1'b1 : ($urandom_range(1) == 1);
      #1;
      if (m_vld && out_rdy) begin
        if (q_dat.size() == 0) chk("rnd_spurious", 1, 0);
        else begin
          e_d = q_dat.pop_front(); e_c = q_cnt.pop_front(); e_o = q_ovf.pop_front();
          chk("rnd_dat", $signed(m_dat), e_d); chk("rnd_cnt", m_cnt, e_c); chk("rnd_ovf", m_ovf, e_o);
        end
      end
      if (in_vld && m_rdy) begin
        s = racc + cur_dat;
        if (s > 64'sd2147483647 || s < -64'sd2147483648) rovf = 1;
        racc = longint'(int'(s));
        rcnt++; sent++; have = 0;
        if (cur_last || rcnt == 255) begin
          q_dat.push_back(int'(racc)); q_cnt.push_back(rcnt); q_ovf.push_back(rovf);
          racc = 0; rcnt = 0; rovf = 0;
        end
      end
    end
    chk("rnd_timeout", cyc < 60000, 1);
    chk("rnd_sent", sent, NBEATS);
    chk("rnd_drain", q_dat.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
